// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states, frame
// width and a helper for sizing the per-bit cycle counter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  // Width of a counter that must hold values up to clks_per_bit-1.
  function automatic int uart_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// RESET_VALUE sets the value both flops take on reset, so an idle-high line
// does not look like an active edge while reset is released.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Produces single-cycle byte strobes with no backpressure; framing and parity
// errors are strobed in the cycle tvalid would have appeared and the byte is
// dropped. A low stop bit parks the FSM in BREAK until the line goes high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       framing_error,
  output logic       parity_error
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = uart_cnt_width(N);

  // START is entered one cycle after t0, so loading H-1 lands the start-bit
  // sample on t0+H; each later bit is a full N cycles after the previous one.
  localparam logic [CW-1:0] HALF_LOAD = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(N - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CW-1:0]             cyc_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                      par_bit;
`endif

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk    (clk),
    .areset (areset),
    .d      (rx),
    .q      (rx_s)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  // Receive FSM: mid-bit sampling, shifting and one-cycle result strobes.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      m_axis_tvalid <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cyc_cnt <= HALF_LOAD;
            state   <= START;
          end
        end

        START: begin
          if (cyc_cnt == '0) begin
            if (!rx_s) begin
              cyc_cnt <= BIT_LOAD;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch.
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end

        DATA: begin
          if (cyc_cnt == '0) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            cyc_cnt <= BIT_LOAD;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cyc_cnt == '0) begin
            par_bit <= rx_s;
            cyc_cnt <= BIT_LOAD;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end
`endif

        STOP: begin
          if (cyc_cnt == '0) begin
            if (!rx_s) begin
              // Framing wins over parity; wait out any break condition.
              framing_error <= 1'b1;
              state         <= BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift, par_bit}) begin
              parity_error <= 1'b1;
              state        <= IDLE;
`endif
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= shift;
              state         <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt - 1'b1;
          end
        end

        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 16. Stimulus pushes the
// expected strobe (kind, data, cycle) into queues; a negedge monitor pops and
// compares every strobe the receiver presents. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + H + 10 * N + 1;
`else
  localparam int LAT = 2 + H + 9 * N + 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       rx = 1'b1;
  logic       m_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic       framing_error;
  logic       parity_error;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t byte_q[$];
  int   fe_q[$];
  int   pe_q[$];

  uart_rx #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .rx            (rx),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .framing_error (framing_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Holds the line at v for one bit period; assumes posedge+1 alignment.
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) hold_bit(1'b1);
  endtask

  // kind: 0 = byte expected, 1 = framing error expected, 2 = parity error.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_flip, input int kind);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + LAT;
    if (kind == 0) byte_q.push_back(e);
    else if (kind == 1) fe_q.push_back(e.cyc);
    else pe_q.push_back(e.cyc);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    hold_bit(stop_bit);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 ||
        framing_error !== 1'b0 || parity_error !== 1'b0) begin
      errors++;
      $display("FAIL %s got tvalid=%b tdata=%02h fe=%b pe=%b want all 0",
               tag, m_axis_tvalid, m_axis_tdata, framing_error, parity_error);
    end else begin
      $display("ok   %s outputs zero", tag);
    end
  endtask

  // Monitor: every strobe is matched against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (!areset) begin
      if (m_axis_tvalid) begin
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL tvalid_unexpected got data=%02h cycle=%0d want no strobe",
                   m_axis_tdata, cyc);
        end else begin
          e = byte_q.pop_front();
          if (m_axis_tdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL byte got data=%02h cycle=%0d want data=%02h cycle=%0d",
                     m_axis_tdata, cyc, e.data, e.cyc);
          end else begin
            $display("ok   byte data=%02h cycle=%0d", m_axis_tdata, cyc);
          end
        end
        if (framing_error || parity_error) begin
          errors++;
          $display("FAIL strobe_overlap got fe=%b pe=%b with tvalid want 0", framing_error, parity_error);
        end
      end
      if (framing_error) begin
        checks++;
        if (fe_q.size() == 0) begin
          errors++;
          $display("FAIL framing_unexpected got cycle=%0d want no strobe", cyc);
        end else begin
          c = fe_q.pop_front();
          if (cyc != c) begin
            errors++;
            $display("FAIL framing_cycle got %0d want %0d", cyc, c);
          end else begin
            $display("ok   framing_error cycle=%0d", cyc);
          end
        end
      end
      if (parity_error) begin
        checks++;
        if (pe_q.size() == 0) begin
          errors++;
          $display("FAIL parity_unexpected got cycle=%0d want no strobe", cyc);
        end else begin
          c = pe_q.pop_front();
          if (cyc != c) begin
            errors++;
            $display("FAIL parity_cycle got %0d want %0d", cyc, c);
          end else begin
            $display("ok   parity_error cycle=%0d", cyc);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_initial");
    @(posedge clk);
    #1;
    areset = 1'b0;
    idle_bits(2);

    // Clean frame, exact latency
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle_bits(2);

    // Short glitch, then a clean frame
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_bits(3);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle_bits(2);

    // Low stop bit, long break, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    for (int i = 0; i < 40; i++) hold_bit(1'b0);
    idle_bits(1);
    send_frame(8'h55, 1'b1, 1'b0, 0);
    idle_bits(2);

    // Back-to-back frames at full line rate
    send_frame(8'h4D, 1'b1, 1'b0, 0);
    send_frame(8'h49, 1'b1, 1'b0, 0);
    send_frame(8'h4C, 1'b1, 1'b0, 0);
    idle_bits(2);

    // Reset in the middle of data bit 3 of 0xFF
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b1);
    rx = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    areset = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_midbyte_a");
    @(negedge clk);
    check_outputs_zero("reset_midbyte_b");
    @(posedge clk);
    #1;
    areset = 1'b0;
    idle_bits(12);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle_bits(2);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, parity bit 1 is right
    send_frame(8'h07, 1'b1, 1'b1, 2);
    idle_bits(2);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle_bits(2);
`endif

    idle_bits(20);

    // Every expected strobe must have appeared
    checks++;
    if (byte_q.size() != 0) begin
      errors++;
      $display("FAIL bytes_missing got %0d outstanding want 0", byte_q.size());
    end
    checks++;
    if (fe_q.size() != 0) begin
      errors++;
      $display("FAIL framing_missing got %0d outstanding want 0", fe_q.size());
    end
    checks++;
    if (pe_q.size() != 0) begin
      errors++;
      $display("FAIL parity_missing got %0d outstanding want 0", pe_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deserialises an asynchronous 8N1 UART line into single-cycle byte strobes. Sits directly upstream of the bootstrap unlocker and any other byte consumer: its `m_axis_*` outputs drive their `s_axis_*` inputs. There is no backpressure. Framing and optional parity errors are flagged and the offending byte is dropped.

## Interface
- `CLKS_PER_BIT`, default 104: clk cycles per UART bit; must be ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idles high.
- `m_axis_tvalid`  out  1  one-cycle strobe, received byte valid.
- `m_axis_tdata`  out  8  received byte, LSB first on the line.
- `framing_error`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_error`  out  1  one-cycle strobe: parity mismatch; constant 0 unless the parity feature is compiled in.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`); both flops reset to 1.
- Define `N = CLKS_PER_BIT` and `H = N/2`, using floor. The bit counter is 3 bits. The cycle counter is `$clog2(N)` bits.
- **IDLE:** on the first cycle `rx_s == 0` (call it t0), load the cycle counter and go to START.
- **START:** at t0+H, sample `rx_s`.
  - Sample 0: go to DATA.
  - Sample 1: glitch. Return to IDLE with no output.
- **DATA:** sample bit i (i = 0..7) at t0+H+(i+1)·N and shift it in LSB first. After bit 7, go to STOP, or to PARITY when compiled in.
- **STOP:** sample at t0+H+9N (t0+H+10N with parity).
  - Sample 1: assert `m_axis_tvalid` the next cycle with `m_axis_tdata` = shifted byte. Go to IDLE.
  - Sample 0: pulse `framing_error`, do not assert tvalid, and go to BREAK.
- **BREAK:** wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line, or break condition, from producing repeated bytes.
- Returning to IDLE at mid-stop lets a start bit that follows immediately be detected.
- Reset values, whether by `areset` at any time including mid-byte:
  - State IDLE; all counters 0; shift register 0.
  - `m_axis_tvalid`, `framing_error` and `parity_error` all 0.
  - `m_axis_tdata` 0.
- `m_axis_tdata` holds its last value between strobes. Consumers must only use it when tvalid is high.

## Timing
- Sampling: bit centres are nominally at the middle of each bit. Total tolerated baud mismatch is about ±4 % at N ≥ 16.
- Latency: `m_axis_tvalid` is high exactly in cycle t0+H+9N+1 (t0+H+10N+1 with parity). It lasts 1 cycle.
- Pin-to-t0 adds 2 cycles of synchroniser delay.
- Error strobes occur in the same cycle tvalid would have. `framing_error` and `parity_error` are never both asserted together with tvalid.
- Maximum throughput: one byte per 10N cycles (11N with parity). No byte is lost at full line rate.

## Configuration
- The macro `UART_RX_PARITY_EN` controls the parity feature.
- **Defined:**
  - The frame is 8E1. A PARITY state samples at t0+H+9N.
  - If the XOR of the data and parity bits is 1, `parity_error` pulses in the post-stop cycle and the byte is dropped, with no tvalid.
  - Framing has priority: if the stop bit is low, only `framing_error` pulses.
- **Undefined:** the frame is 8N1, the PARITY state is absent, and `parity_error` is tied 0.

## Structure
- Package `uart_pkg`:
  - State enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `UART_DATA_BITS = 8`.
  - Helper localparam for counter width.
- Sub-module `sync_2ff`: generic 2-flop synchroniser with a reset-value parameter, instantiated here with reset value 1. Reusable by other bootstrap inputs.

## Test plan
- N=16, send 0xA5, clean frame → `m_axis_tvalid` high for exactly one cycle at t0+8+144+1, with `m_axis_tdata`=0xA5; no error strobes.
- N=16, drive `rx` low for 4 cycles, then high → no tvalid and no error strobe; the next clean frame with 0x3C is received correctly.
- N=16, send 0x3C with the stop bit low, then hold `rx` low for 40 bit periods, then send 0x55:
  - one `framing_error` pulse and no tvalid during the low period;
  - then exactly one tvalid with 0x55.
- Send 0x4D, 0x49, 0x4C back-to-back with no idle gap → three tvalid pulses 160 cycles apart, carrying data 0x4D, 0x49, 0x4C.
- Assert `areset` midway through data bit 3 of 0xFF, release, then send 0x12:
  - all outputs are 0 during reset;
  - no spurious byte is output;
  - 0x12 is received.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0 → `parity_error` pulses once and there is no tvalid. With parity bit 1 → tvalid with 0x07.
